pipe_memwb_stage: RTL

- Parametrised MEM/WB pipeline stage for the rv32imc core, sitting between the data-memory interface and the register-file write port.
- Generalises the fixed MEM/WB register in four ways:
  - valid/ready handshake with stall and flush;
  - multi-cycle load wait with a timeout counter;
  - in-stage byte/half extraction with sign/zero extension and misalignment detection;
  - link-address writeback of PC+2 or PC+4 for compressed or normal jumps.

---
 rtl/loopyV_data_types.sv | 24 ++
 rtl/load_extract.sv | 48 ++++
 rtl/pipe_memwb_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/loopyV_data_types.sv
// Shared types for the loopyV rv32imc pipeline: writeback-source select, load funct3 codes,
// and the MEM/WB stage FSM states.
package loopyV_data_types;

    typedef enum logic [1:0] {
        WB_SEL_ALU     = 2'b00,
        WB_SEL_IMM     = 2'b01,
        WB_SEL_LOAD    = 2'b10,
        WB_SEL_PC_LINK = 2'b11
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        MEMWB_IDLE      = 2'b00,
        MEMWB_ACTIVE    = 2'b01,
        MEMWB_WAIT_LOAD = 2'b10
    } memwb_state_t;

endpackage

// File: rtl/load_extract.sv
// Combinational load lane extraction with sign/zero extension and a misalignment flag.
// Shared between the MEM/WB stage and the forwarding unit.
module load_extract
    import loopyV_data_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value,
    output logic            misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];

        value      = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: value = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                value      = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = lane[0];
            end
            F3_LHU: begin
                value      = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = lane[0];
            end
            F3_LW: begin
                value      = word;
                misaligned = (lane != 2'd0);
            end
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/pipe_memwb_stage.sv
// MEM/WB pipeline stage: handshake with stall/flush, multi-cycle load wait with timeout,
// in-stage load extraction and link-address writeback.
//
// state      | meaning
// -----------+-------------------------------------------
// IDLE       | no entry held
// ACTIVE     | entry held, first WB cycle
// WAIT_LOAD  | load pending, dmLoadValid not yet seen
module pipe_memwb_stage
    import loopyV_data_types::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_TIMEOUT = 15,
    parameter int TMO_W        = 4
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  validMEM,
    output logic                  readyMEM,
    input  logic                  flushIn,
    input  logic                  stallIn,
    input  logic [REG_ADDR_W-1:0] rdAddrMEM,
    input  logic                  rdWriteEnMEM,
    input  logic [1:0]            destinationSelectMEM,
    input  logic [XLEN-1:0]       pcMEM,
    input  logic                  isCompressedMEM,
    input  logic [XLEN-1:0]       rdWriteDataMEM,
    input  logic [XLEN-1:0]       dmAddrMEM,
    input  logic [2:0]            loadStoreByteSelectMEM,
    input  logic [XLEN-1:0]       dmLoadData,
    input  logic                  dmLoadValid,
    output logic                  validWB,
    output logic [REG_ADDR_W-1:0] rdAddrWB,
    output logic                  rdWriteEnWB,
    output logic [XLEN-1:0]       rdWriteDataWB,
    output logic [XLEN-1:0]       pcWB,
    output logic                  misalignedWB,
    output logic                  loadTimeoutWB
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd_addr;
        logic                  rd_we;
        wb_sel_t               sel;
        logic [XLEN-1:0]       pc;
        logic                  is_c;
        logic [XLEN-1:0]       rd_data;
        logic [1:0]            lane;
        logic [2:0]            funct3;
    } memwb_entry_t;

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(LOAD_TIMEOUT);

    memwb_state_t     state_q;
    memwb_entry_t     ent_q;
    logic [TMO_W-1:0] cnt_q;

    logic            held;
    logic            is_load;
    logic            tmo_hit;
    logic            retire;
    logic            tmo_retire;
    logic            capture;
    logic [XLEN-1:0] ext_value;
    logic            ext_mis;
    logic            mis;
    logic [XLEN-1:0] link_addr;
    logic            unused_addr_hi;

    // Only the byte lane of the load address matters once data arrives word-aligned.
    assign unused_addr_hi = ^dmAddrMEM[XLEN-1:2];

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .word       (dmLoadData),
        .lane       (ent_q.lane),
        .funct3     (ent_q.funct3),
        .value      (ext_value),
        .misaligned (ext_mis)
    );

    assign held       = (state_q != MEMWB_IDLE);
    assign is_load    = (ent_q.sel == WB_SEL_LOAD);
    assign tmo_hit    = (state_q == MEMWB_WAIT_LOAD) && (cnt_q == TMO_LIMIT);
    assign retire     = held && !stallIn && !flushIn && (!is_load || dmLoadValid || tmo_hit);
    // Data arriving in the same cycle as the timeout wins over the abort.
    assign tmo_retire = retire && is_load && !dmLoadValid;
    assign mis        = is_load && ext_mis;
    assign readyMEM   = !stallIn && !flushIn && (!held || retire);
    assign capture    = validMEM && readyMEM;
    assign link_addr  = ent_q.pc + (ent_q.is_c ? XLEN'(2) : XLEN'(4));

    assign validWB       = retire;
    assign rdWriteEnWB   = retire && ent_q.rd_we && (ent_q.rd_addr != '0) && !mis && !tmo_retire;
    assign misalignedWB  = retire && mis;
    assign loadTimeoutWB = tmo_retire;
    assign rdAddrWB      = held ? ent_q.rd_addr : '0;
    assign pcWB          = held ? ent_q.pc : '0;

    always_comb begin
        rdWriteDataWB = '0;
        if (held && !tmo_retire) begin
            case (ent_q.sel)
                WB_SEL_LOAD:    rdWriteDataWB = ext_value;
                WB_SEL_PC_LINK: rdWriteDataWB = link_addr;
                default:        rdWriteDataWB = ent_q.rd_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q <= MEMWB_IDLE;
            ent_q   <= '0;
            cnt_q   <= '0;
        end else if (flushIn) begin
            state_q <= MEMWB_IDLE;
            cnt_q   <= '0;
        end else if (!stallIn) begin
            if (capture) begin
                state_q <= MEMWB_ACTIVE;
                cnt_q   <= '0;
                ent_q   <= '{rd_addr: rdAddrMEM,
                             rd_we:   rdWriteEnMEM,
                             sel:     wb_sel_t'(destinationSelectMEM),
                             pc:      pcMEM,
                             is_c:    isCompressedMEM,
                             rd_data: rdWriteDataMEM,
                             lane:    dmAddrMEM[1:0],
                             funct3:  loadStoreByteSelectMEM};
            end else if (retire) begin
                state_q <= MEMWB_IDLE;
                cnt_q   <= '0;
            end else if (state_q == MEMWB_ACTIVE) begin
                state_q <= MEMWB_WAIT_LOAD;
                cnt_q   <= TMO_W'(1);
            end else if (state_q == MEMWB_WAIT_LOAD) begin
                cnt_q   <= cnt_q + TMO_W'(1);
            end
        end
    end

endmodule
